player_collision_health: RTL

// - Sits downstream of the obstacle generators (lasers and similar blocks). Consumes their obstacle_x/obstacle_y

---
 rtl/player_collision_health.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/player_collision_health.sv
// player_collision_health
// Checks obstacle pixels against the player hitbox. Tracks player HP, with an
// invulnerability window after every non-fatal hit, and reports game over.
//
// Ports
//   pclk         in   pixel clock, the only clock
//   rst          in   synchronous reset, active high
//   hcount_in    in   12b horizontal pixel counter
//   vcount_in    in   12b vertical pixel counter
//   game_on      in   gameplay active
//   menu_on      in   menu displayed, forces return to IDLE
//   player_xpos  in   12b hitbox left edge, latched at pixel (0,0)
//   player_ypos  in   12b hitbox top edge, latched at pixel (0,0)
//   obstacle_x   in   12b x of obstacle pixel this cycle, (0,0) = none
//   obstacle_y   in   12b y of obstacle pixel this cycle
//   hit          out  one-cycle pulse per accepted hit
//   hp           out  3b current HP
//   invuln       out  invulnerability window active
//   game_over    out  high while in DEAD
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no game running, hp=0
// ALIVE  | playing, an inside pixel costs one HP
// INVULN | post-hit grace period, inside pixels ignored
// DEAD   | hp reached 0, held until menu or game end
module player_collision_health #(
  parameter int MAX_HP        = 3,
  parameter int PLAYER_SIZE   = 20,
  parameter int INVULN_CYCLES = 65_000_000
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [11:0] hcount_in,
  input  logic [11:0] vcount_in,
  input  logic        game_on,
  input  logic        menu_on,
  input  logic [11:0] player_xpos,
  input  logic [11:0] player_ypos,
  input  logic [11:0] obstacle_x,
  input  logic [11:0] obstacle_y,
  output logic        hit,
  output logic [2:0]  hp,
  output logic        invuln,
  output logic        game_over
);

  localparam logic [11:0] SIZE_M1  = 12'(PLAYER_SIZE - 1);
  localparam logic [25:0] CNT_LAST = 26'(INVULN_CYCLES - 1);
  localparam logic [2:0]  HP_INIT  = 3'(MAX_HP);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALIVE  = 2'd1,
    INVULN = 2'd2,
    DEAD   = 2'd3
  } state_t;

  state_t      r_state;
  logic [11:0] r_left;
  logic [11:0] r_top;
  logic        r_inside;
  logic [2:0]  r_hp;
  logic        r_invuln;
  logic        r_hit;
  logic [25:0] r_cnt;

  state_t      w_state_nx;
  logic [2:0]  w_hp_nx;
  logic        w_invuln_nx;
  logic        w_hit_nx;
  logic [25:0] w_cnt_nx;

  logic [11:0] w_right;
  logic [11:0] w_bottom;
  logic        w_pixel_valid;
  logic        w_inside;
  logic        w_frame_start;
  logic        w_abort;

  // Box is evaluated against the values latched at the last frame start, so a
  // mid-frame player move never tears the hitbox.
  assign w_right       = r_left + SIZE_M1;
  assign w_bottom      = r_top + SIZE_M1;
  assign w_pixel_valid = (obstacle_x != 12'd0) || (obstacle_y != 12'd0);
  assign w_inside      = w_pixel_valid &&
                         (obstacle_x >= r_left) && (obstacle_x <= w_right) &&
                         (obstacle_y >= r_top)  && (obstacle_y <= w_bottom);
  assign w_frame_start = (hcount_in == 12'd0) && (vcount_in == 12'd0);
  assign w_abort       = menu_on || !game_on;

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_left   <= 12'd0;
      r_top    <= 12'd0;
      r_inside <= 1'b0;
      r_hp     <= 3'd0;
      r_invuln <= 1'b0;
      r_hit    <= 1'b0;
      r_cnt    <= 26'd0;
    end else begin
      if (w_frame_start) begin
        r_left <= player_xpos;
        r_top  <= player_ypos;
      end
      r_inside <= w_inside;
      r_state  <= w_state_nx;
      r_hp     <= w_hp_nx;
      r_invuln <= w_invuln_nx;
      r_hit    <= w_hit_nx;
      r_cnt    <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_hp_nx     = r_hp;
    w_invuln_nx = r_invuln;
    w_hit_nx    = 1'b0;
    w_cnt_nx    = r_cnt;

    // Leaving the game outranks any hit arriving on the same edge.
    if (r_state != IDLE && w_abort) begin
      w_state_nx  = IDLE;
      w_hp_nx     = 3'd0;
      w_invuln_nx = 1'b0;
      w_cnt_nx    = 26'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (game_on && !menu_on) begin
            w_state_nx = ALIVE;
            w_hp_nx    = HP_INIT;
          end
        end
        ALIVE: begin
          if (r_inside) begin
            w_hit_nx = 1'b1;
            w_hp_nx  = r_hp - 3'd1;
            if (r_hp == 3'd1) begin
              w_state_nx = DEAD;
            end else begin
              w_state_nx  = INVULN;
              w_invuln_nx = 1'b1;
              w_cnt_nx    = 26'd0;
            end
          end
        end
        INVULN: begin
          if (r_cnt == CNT_LAST) begin
            w_state_nx  = ALIVE;
            w_invuln_nx = 1'b0;
            w_cnt_nx    = 26'd0;
          end else begin
            w_cnt_nx = r_cnt + 26'd1;
          end
        end
        DEAD: begin
          w_hp_nx = 3'd0;
        end
        default: begin
          w_state_nx = IDLE;
        end
      endcase
    end
  end

  assign hit       = r_hit;
  assign hp        = r_hp;
  assign invuln    = r_invuln;
  assign game_over = (r_state == DEAD);

endmodule
